// File: rtl/adder_pipe_nbit_if.sv
// Operand and result handshake bundle for the pipelined adder.
// The master side offers operands and consumes results; the slave side is the adder.
interface adder_pipe_nbit_if #(
    parameter int unsigned N = 32
);
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         cin;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] sum;
    logic         cout;
    logic         ovf;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );
endinterface

// File: rtl/adder_pipe_nbit.sv
// Pipelined N-bit add/subtract: STAGES carry segments of W bits each,
// valid/ready on both sides, with a signed-overflow flag on the result.
module adder_pipe_nbit #(
    parameter int unsigned N      = 32,
    parameter int unsigned STAGES = 4
) (
    input  logic              clk,
    input  logic              rst,
    adder_pipe_nbit_if.slave  bus
);
    localparam int unsigned W = N / STAGES;

    // Rank k holds the beat after segment k has been added.
    logic [STAGES-1:0] vld_q;
    logic [STAGES-1:0] c_q;
    logic [N-1:0]      a_q   [STAGES];
    logic [N-1:0]      b_q   [STAGES];
    logic [N-1:0]      res_q [STAGES];
    logic              ovf_q;

    logic [STAGES-1:0] s_vld;
    logic [STAGES-1:0] s_c;
    logic [N-1:0]      s_a   [STAGES];
    logic [N-1:0]      s_b   [STAGES];
    logic [N-1:0]      s_res [STAGES];

    logic [STAGES-1:0] n_c;
    logic [N-1:0]      n_res [STAGES];
    logic              n_ovf;

    logic              advance;

    // Whole pipeline moves together; it only freezes when a result is waiting.
    assign advance      = !vld_q[STAGES-1] || bus.out_ready;
    assign bus.in_ready = advance && !rst;

    // Stage inputs: rank 0 sees the ports (subtract folded in), later ranks see the previous rank.
    always_comb begin
        s_vld[0] = bus.in_valid;
        s_a[0]   = bus.a;
        s_b[0]   = bus.sub ? ~bus.b : bus.b;
        s_c[0]   = bus.sub ^ bus.cin;
        s_res[0] = '0;
        for (int k = 1; k < int'(STAGES); k++) begin
            s_vld[k] = vld_q[k-1];
            s_a[k]   = a_q[k-1];
            s_b[k]   = b_q[k-1];
            s_c[k]   = c_q[k-1];
            s_res[k] = res_q[k-1];
        end
    end

    // Each rank adds its own W-bit slice and splices it into the partial result.
    always_comb begin
        logic [W:0] seg;
        seg   = '0;
        n_c   = '0;
        for (int k = 0; k < int'(STAGES); k++) begin
            seg      = (W+1)'(s_a[k][k*W +: W]) + (W+1)'(s_b[k][k*W +: W]) + (W+1)'(s_c[k]);
            n_res[k] = s_res[k];
            n_res[k][k*W +: W] = seg[W-1:0];
            n_c[k]   = seg[W];
        end
        // Carry into the MSB is recovered as a ^ b ^ sum at that bit.
        n_ovf = s_a[STAGES-1][N-1] ^ s_b[STAGES-1][N-1]
              ^ n_res[STAGES-1][N-1] ^ n_c[STAGES-1];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= '0;
            c_q   <= '0;
            ovf_q <= 1'b0;
            for (int k = 0; k < int'(STAGES); k++) begin
                a_q[k]   <= '0;
                b_q[k]   <= '0;
                res_q[k] <= '0;
            end
        end else if (advance) begin
            vld_q <= s_vld;
            c_q   <= n_c;
            ovf_q <= n_ovf;
            for (int k = 0; k < int'(STAGES); k++) begin
                a_q[k]   <= s_a[k];
                b_q[k]   <= s_b[k];
                res_q[k] <= n_res[k];
            end
        end
    end

    assign bus.out_valid = vld_q[STAGES-1];
    assign bus.sum       = res_q[STAGES-1];
    assign bus.cout      = c_q[STAGES-1];
    assign bus.ovf       = ovf_q;
endmodule
